// File: rtl/router_output_ctrl_if.sv
// Request/grant/packet bundle from the input controllers plus the outgoing link handshake.
interface router_output_ctrl_if #(
    parameter int DATA_W  = 64,
    parameter int NUM_REQ = 3
);
    logic                        polarity;
    logic [NUM_REQ-1:0]          in2out_req;
    logic [NUM_REQ-1:0]          out2in_gnt;
    logic [NUM_REQ*DATA_W-1:0]   in2out_din;
    logic                        out2ch_vld;
    logic                        ch2out_rdy;
    logic [DATA_W-1:0]           out2ch_dout;

    modport slave (
        input  polarity, in2out_req, in2out_din, ch2out_rdy,
        output out2in_gnt, out2ch_vld, out2ch_dout
    );

    modport master (
        output polarity, in2out_req, in2out_din, ch2out_rdy,
        input  out2in_gnt, out2ch_vld, out2ch_dout
    );
endinterface

// File: rtl/router_output_ctrl.sv
// Ring-router output port: round-robin grant into an even/odd VC buffer, drained onto the link by vld/rdy.
// Latency: 1 cycle grant-to-link; full entry blocks grants for its phase and is re-offered every 2 cycles.
module router_output_ctrl #(
    parameter int DATA_W  = 64,
    parameter int NUM_REQ = 3,
    parameter int HOP_LSB = 48,
    parameter int HOP_W   = 8
) (
    input  logic clk,
    input  logic rst,
    router_output_ctrl_if.slave bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [DATA_W-1:0]  vc_buf_q [2];
    logic [DATA_W-1:0]  vc_buf_d [2];
    logic [1:0]         full_q, full_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic               wsel, rsel;
    logic               gnt_any;
    logic [NUM_REQ-1:0] gnt;
    logic [DATA_W-1:0]  gnt_pkt, wr_pkt;
    logic [HOP_W-1:0]   hop;
    logic               vld, xfer;

    // Write and read phases are always opposite entries, so no entry is touched by both in one cycle.
    assign wsel = ~bus.polarity;
    assign rsel =  bus.polarity;

    // Round-robin: scan rr_ptr..NUM_REQ-1 first, then wrap to 0..rr_ptr-1.
    always_comb begin
        gnt      = '0;
        gnt_any  = 1'b0;
        gnt_pkt  = '0;
        rr_ptr_d = rr_ptr_q;
        if (!rst && !full_q[wsel]) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!gnt_any && bus.in2out_req[k] && k >= int'(rr_ptr_q)) begin
                    gnt_any  = 1'b1;
                    gnt[k]   = 1'b1;
                    gnt_pkt  = bus.in2out_din[k*DATA_W +: DATA_W];
                    rr_ptr_d = PTR_W'((k + 1) % NUM_REQ);
                end
            end
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!gnt_any && bus.in2out_req[k]) begin
                    gnt_any  = 1'b1;
                    gnt[k]   = 1'b1;
                    gnt_pkt  = bus.in2out_din[k*DATA_W +: DATA_W];
                    rr_ptr_d = PTR_W'((k + 1) % NUM_REQ);
                end
            end
        end
    end

    // Hop count saturates at zero rather than wrapping.
    always_comb begin
        hop    = gnt_pkt[HOP_LSB +: HOP_W];
        wr_pkt = gnt_pkt;
        wr_pkt[HOP_LSB +: HOP_W] = (hop == '0) ? '0 : hop - 1'b1;
    end

    assign vld  = full_q[rsel] & ~rst;
    assign xfer = vld & bus.ch2out_rdy;

    always_comb begin
        full_d   = full_q;
        vc_buf_d = vc_buf_q;
        if (gnt_any) begin
            full_d[wsel]   = 1'b1;
            vc_buf_d[wsel] = wr_pkt;
        end
        if (xfer) begin
            full_d[rsel] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q   <= '0;
            vc_buf_q <= '{default: '0};
            rr_ptr_q <= '0;
        end else begin
            full_q   <= full_d;
            vc_buf_q <= vc_buf_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign bus.out2in_gnt  = gnt;
    assign bus.out2ch_vld  = vld;
    assign bus.out2ch_dout = vld ? vc_buf_q[rsel] : '0;

endmodule

// File: tb/tb_router_output_ctrl.sv
// Directed bench for router_output_ctrl: per-cycle compare against a behavioural model plus literal spot checks.
module tb_router_output_ctrl;
    localparam int DW = 64;
    localparam int NR = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    router_output_ctrl_if #(.DATA_W(DW), .NUM_REQ(NR)) bus ();

    router_output_ctrl #(.DATA_W(DW), .NUM_REQ(NR), .HOP_LSB(48), .HOP_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors    = 0;
    int miscompares = 0;
    int cyc_n      = 0;
    bit chk_en     = 1'b0;
    logic [DW-1:0] d [NR];

    // Behavioural model: two VC slots, a priority pointer, packets with decremented hop.
    bit            m_full [2];
    logic [DW-1:0] m_pkt  [2];
    int            m_ptr;

    initial begin
        m_full = '{0, 0};
        m_pkt  = '{64'h0, 64'h0};
        m_ptr  = 0;
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc_n, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] hopdec(input logic [DW-1:0] p);
        int h = int'(p[55:48]);
        if (h > 0) h = h - 1;
        p[55:48] = 8'(h);
        return p;
    endfunction

    function automatic int m_winner();
        int w = -1;
        int wr = bus.polarity ? 0 : 1;
        if (!rst && !m_full[wr])
            for (int i = 0; i < NR; i++)
                if (w < 0 && bus.in2out_req[(m_ptr + i) % NR]) w = (m_ptr + i) % NR;
        return w;
    endfunction

    function automatic logic m_vld();
        return !rst && m_full[bus.polarity ? 1 : 0];
    endfunction

    always @(posedge clk) begin
        int w;
        int wr;
        int rd;
        w  = m_winner();
        wr = bus.polarity ? 0 : 1;
        rd = bus.polarity ? 1 : 0;
        if (rst) begin
            m_full <= '{0, 0};
            m_pkt  <= '{64'h0, 64'h0};
            m_ptr  <= 0;
        end else begin
            if (w >= 0) begin
                m_full[wr] <= 1'b1;
                m_pkt[wr]  <= hopdec(bus.in2out_din[w*DW +: DW]);
                m_ptr      <= (w + 1) % NR;
            end
            if (m_vld() && bus.ch2out_rdy) m_full[rd] <= 1'b0;
        end
    end

    always @(negedge clk) begin
        int w;
        logic [NR-1:0] eg;
        if (chk_en) begin
            w  = m_winner();
            eg = '0;
            if (w >= 0) eg[w] = 1'b1;
            chk("model_gnt", DW'(bus.out2in_gnt), DW'(eg));
            chk("model_vld", DW'(bus.out2ch_vld), DW'(m_vld()));
            chk("model_dout", bus.out2ch_dout, m_vld() ? m_pkt[bus.polarity ? 1 : 0] : 64'h0);
        end
    end

    task automatic step(input logic r, input logic p, input logic [NR-1:0] rq, input logic rd);
        @(posedge clk);
        #1;
        cyc_n++;
        rst            = r;
        bus.polarity   = p;
        bus.in2out_req = rq;
        bus.ch2out_rdy = rd;
        bus.in2out_din = {d[2], d[1], d[0]};
        chk_en         = 1'b1;
        @(negedge clk);
        #1;
    endtask

    localparam logic [DW-1:0] D0  = 64'h8A05_0000_0000_0010;
    localparam logic [DW-1:0] D0F = 64'h8A04_0000_0000_0010;
    localparam logic [DW-1:0] D2  = 64'h1200_0000_0000_0012;

    initial begin
        logic [NR-1:0] rr_exp [6];
        rr_exp = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
        d[0] = D0;
        d[1] = 64'h4C01_0000_0000_0011;
        d[2] = D2;
        rst = 1'b1;
        bus.polarity   = 1'b0;
        bus.in2out_req = 3'b111;
        bus.ch2out_rdy = 1'b0;
        bus.in2out_din = {d[2], d[1], d[0]};

        // Reset with all requests asserted
        for (int i = 0; i < 3; i++) begin
            step(1'b1, i[0], 3'b111, 1'b0);
            chk("rst_gnt", DW'(bus.out2in_gnt), 64'h0);
            chk("rst_vld", DW'(bus.out2ch_vld), 64'h0);
            chk("rst_dout", bus.out2ch_dout, 64'h0);
        end
        step(1'b0, 1'b1, 3'b111, 1'b1);
        chk("first_gnt", DW'(bus.out2in_gnt), 64'h1);
        step(1'b0, 1'b0, 3'b000, 1'b1);
        chk("first_dout", bus.out2ch_dout, D0F);

        // Single pass: hop field of this packet is already zero, so it forwards unchanged
        d[0] = 64'h0000_0300_0000_00AA;
        step(1'b0, 1'b1, 3'b001, 1'b1);
        chk("single_gnt", DW'(bus.out2in_gnt), 64'h1);
        step(1'b0, 1'b0, 3'b000, 1'b1);
        chk("single_vld", DW'(bus.out2ch_vld), 64'h1);
        chk("single_dout", bus.out2ch_dout, 64'h0000_0300_0000_00AA);
        step(1'b0, 1'b1, 3'b000, 1'b1);
        chk("single_vld_off", DW'(bus.out2ch_vld), 64'h0);
        d[0] = 64'h0003_0000_0000_00AA;
        step(1'b0, 1'b0, 3'b001, 1'b1);
        chk("odd_gnt", DW'(bus.out2in_gnt), 64'h1);
        step(1'b0, 1'b1, 3'b000, 1'b1);
        chk("odd_dout", bus.out2ch_dout, 64'h0002_0000_0000_00AA);

        // Round-robin with all requesting; pointer sits at 1 here
        d[0] = D0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, i[0], 3'b111, 1'b1);
            chk("rr_gnt", DW'(bus.out2in_gnt), DW'(rr_exp[i]));
        end
        step(1'b0, 1'b0, 3'b000, 1'b1);
        step(1'b0, 1'b1, 3'b000, 1'b1);

        // Backpressure: two grants fill both VCs, then data is held
        step(1'b0, 1'b0, 3'b001, 1'b0);
        chk("bp_gnt0", DW'(bus.out2in_gnt), 64'h1);
        step(1'b0, 1'b1, 3'b001, 1'b0);
        chk("bp_gnt1", DW'(bus.out2in_gnt), 64'h1);
        chk("bp_dout1", bus.out2ch_dout, D0F);
        step(1'b0, 1'b0, 3'b001, 1'b0);
        chk("bp_gnt2", DW'(bus.out2in_gnt), 64'h0);
        chk("bp_vld2", DW'(bus.out2ch_vld), 64'h1);
        step(1'b0, 1'b1, 3'b001, 1'b0);
        chk("bp_gnt3", DW'(bus.out2in_gnt), 64'h0);
        chk("bp_dout3", bus.out2ch_dout, D0F);
        step(1'b0, 1'b0, 3'b001, 1'b1);
        chk("drain_gnt", DW'(bus.out2in_gnt), 64'h0);
        step(1'b0, 1'b1, 3'b001, 1'b1);
        chk("resume_gnt", DW'(bus.out2in_gnt), 64'h1);
        step(1'b0, 1'b0, 3'b001, 1'b1);

        // Hop saturation on a zero hop field
        step(1'b0, 1'b1, 3'b100, 1'b1);
        chk("sat_gnt", DW'(bus.out2in_gnt), 64'h4);
        step(1'b0, 1'b0, 3'b011, 1'b0);
        chk("sat_dout", bus.out2ch_dout, D2);
        step(1'b0, 1'b1, 3'b111, 1'b0);
        chk("both_full_gnt", DW'(bus.out2in_gnt), 64'h0);

        // Reset with both entries full drops them and restarts the pointer
        step(1'b1, 1'b0, 3'b111, 1'b0);
        chk("midrst_gnt", DW'(bus.out2in_gnt), 64'h0);
        step(1'b0, 1'b1, 3'b000, 1'b1);
        chk("midrst_vld_odd", DW'(bus.out2ch_vld), 64'h0);
        step(1'b0, 1'b0, 3'b000, 1'b1);
        chk("midrst_vld_even", DW'(bus.out2ch_vld), 64'h0);
        step(1'b0, 1'b1, 3'b111, 1'b1);
        chk("midrst_ptr", DW'(bus.out2in_gnt), 64'h1);
        step(1'b0, 1'b0, 3'b000, 1'b1);
        chk("final_dout", bus.out2ch_dout, D0F);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
